// File: rtl/spi_target_pkg.sv
// spi_target_pkg: frame sizes, TX filler, RX FIFO depth, FSM state type and
// byte-order helpers shared by the SPI responder.
package spi_target_pkg;

    localparam int          FRAME8       = 8;
    localparam int          FRAME32      = 32;
    localparam logic [31:0] TX_FILLER    = 32'hFFFF_FFFF;
    localparam int          RXFIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Reverse byte order: 32-bit frames travel byte 0 first, each byte MSB first.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Arrange a TX word so that bit 31 is always the next bit on the wire.
    function automatic logic [31:0] tx_order(input logic [31:0] w, input logic wide);
        if (wide) begin
            return byte_swap(w);
        end else begin
            return {w[7:0], 24'hFF_FFFF};
        end
    endfunction

endpackage

// File: rtl/spi_target_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous input plus a third
// flop that turns transitions of the synchronised value into 1-clk pulses.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchroniser chain and edge-detect register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder oversampling SCLK/MOSI/SS with clk.
// Exchanges 8-bit or 32-bit frames through a one-word TX buffer and an RX
// register. Define SPI_TARGET_RXFIFO_EN to replace the RX register with a
// small RX FIFO.
module spi_target
    import spi_target_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS,
    output logic        MISO,
    input  logic        wide,
    input  logic [31:0] txData,
    input  logic        txLoad,
    output logic        txRdy,
    output logic [31:0] rxData,
    output logic        rxRdy,
    input  logic        rxDone,
    output logic        overrun,
    output logic        underrun
);

    logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
    logic mosi_s1_q, mosi_s;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wide_q, wide_d;
    logic        miso_q, miso_d;
    logic [31:0] tx_buf_q, tx_buf_d;
    logic [31:0] tx_sh_q, tx_sh_d;
    logic        tx_rdy_q, tx_rdy_d;
    logic [31:0] rx_sh_q, rx_sh_d;
    logic        ovr_q, ovr_d;
    logic        unr_q, unr_d;
    logic        frame_start_s, frame_done_s, last_bit_s;
    logic [31:0] rx_next_s, rx_word_s;

`ifdef SPI_TARGET_RXFIFO_EN
    localparam logic [2:0] FIFO_FULL = 3'(RXFIFO_DEPTH);
    logic [31:0] fifo_mem_q [RXFIFO_DEPTH];
    logic [31:0] fifo_mem_d [RXFIFO_DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  fifo_cnt_q, fifo_cnt_d;
    logic        push_s, pop_s;
`else
    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_rdy_q, rx_rdy_d;
`endif

    sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk (clk), .rst (rst), .d (SCLK), .rise (sclk_rise_s), .fall (sclk_fall_s)
    );

    sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk (clk), .rst (rst), .d (SS), .rise (ss_rise_s), .fall (ss_fall_s)
    );

    // MOSI synchroniser; its latency matches the SCLK edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_s1_q <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_s1_q <= MOSI;
            mosi_s    <= mosi_s1_q;
        end
    end

    // Next-state logic for the frame FSM, TX path and RX path
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wide_d        = wide_q;
        miso_d        = miso_q;
        tx_buf_d      = tx_buf_q;
        tx_sh_d       = tx_sh_q;
        tx_rdy_d      = tx_rdy_q;
        rx_sh_d       = rx_sh_q;
        ovr_d         = ovr_q;
        unr_d         = unr_q;
        frame_start_s = 1'b0;
        frame_done_s  = 1'b0;
        rx_next_s     = {rx_sh_q[30:0], mosi_s};
        rx_word_s     = wide_q ? byte_swap(rx_next_s) : {24'h00_0000, rx_next_s[7:0]};
        last_bit_s    = wide_q ? (cnt_q == 6'(FRAME32 - 1)) : (cnt_q == 6'(FRAME8 - 1));

        // Local side fills the TX buffer only while it is empty
        if (txLoad && tx_rdy_q) begin
            tx_buf_d = txData;
            tx_rdy_d = 1'b0;
        end else begin
            tx_buf_d = tx_buf_q;
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b1;
                if (ss_fall_s) begin
                    state_d       = ACTIVE;
                    frame_start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (ss_rise_s) begin
                    // Partial frame is dropped; RX side untouched
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                    miso_d  = 1'b1;
                end else if (sclk_rise_s) begin
                    rx_sh_d = rx_next_s;
                    if (last_bit_s) begin
                        frame_done_s  = 1'b1;
                        frame_start_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else if (sclk_fall_s && (cnt_q != 6'd0)) begin
                    // No advance on the fall that follows a frame boundary:
                    // the new frame's first bit must stay on the wire
                    tx_sh_d = {tx_sh_q[30:0], 1'b1};
                    miso_d  = tx_sh_q[30];
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b1;
            end
        endcase

        if (frame_start_s) begin
            wide_d = wide;
            cnt_d  = 6'd0;
            if (!tx_rdy_q) begin
                tx_sh_d  = tx_order(tx_buf_q, wide);
                tx_rdy_d = 1'b1;
            end else begin
                tx_sh_d = tx_order(TX_FILLER, wide);
                unr_d   = 1'b1;
            end
            miso_d = tx_sh_d[31];
        end else begin
            wide_d = wide_q;
        end

`ifdef SPI_TARGET_RXFIFO_EN
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pop_s      = rxDone && (fifo_cnt_q != 3'd0);
        push_s     = frame_done_s && (fifo_cnt_q != FIFO_FULL);
        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = rx_word_s;
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {2'b00, push_s} - {2'b00, pop_s};
        if (frame_done_s && !push_s) begin
            ovr_d = 1'b1;
        end else if (pop_s && (fifo_cnt_d == 3'd0)) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
`else
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q;
        if (frame_done_s) begin
            // A new frame wins over a simultaneous acknowledge
            rx_data_d = rx_word_s;
            rx_rdy_d  = 1'b1;
            if (rxDone) begin
                ovr_d = 1'b0;
            end else if (rx_rdy_q) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = ovr_q;
            end
        end else if (rxDone) begin
            rx_rdy_d = 1'b0;
            ovr_d    = 1'b0;
        end else begin
            rx_rdy_d = rx_rdy_q;
        end
`endif
    end

    // State register for the FSM, TX path, RX path and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            wide_q   <= 1'b0;
            miso_q   <= 1'b1;
            tx_buf_q <= 32'h0000_0000;
            tx_sh_q  <= 32'hFFFF_FFFF;
            tx_rdy_q <= 1'b1;
            rx_sh_q  <= 32'h0000_0000;
            ovr_q    <= 1'b0;
            unr_q    <= 1'b0;
`ifdef SPI_TARGET_RXFIFO_EN
            for (int i = 0; i < RXFIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 32'h0000_0000;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
`else
            rx_data_q <= 32'h0000_0000;
            rx_rdy_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wide_q   <= wide_d;
            miso_q   <= miso_d;
            tx_buf_q <= tx_buf_d;
            tx_sh_q  <= tx_sh_d;
            tx_rdy_q <= tx_rdy_d;
            rx_sh_q  <= rx_sh_d;
            ovr_q    <= ovr_d;
            unr_q    <= unr_d;
`ifdef SPI_TARGET_RXFIFO_EN
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
`else
            rx_data_q <= rx_data_d;
            rx_rdy_q  <= rx_rdy_d;
`endif
        end
    end

    assign MISO     = miso_q;
    assign txRdy    = tx_rdy_q;
    assign overrun  = ovr_q;
    assign underrun = unr_q;
`ifdef SPI_TARGET_RXFIFO_EN
    assign rxRdy  = (fifo_cnt_q != 3'd0);
    assign rxData = fifo_mem_q[rd_ptr_q];
`else
    assign rxRdy  = rx_rdy_q;
    assign rxData = rx_data_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: drives spi_target as an SPI mode-0 master with directed and
// randomized frames, comparing against a word-level model of the responder.
module tb_spi_target;

    logic        clk = 1'b0;
    logic        rst, SCLK, MOSI, SS, MISO, wide, txLoad, txRdy, rxRdy, rxDone;
    logic        overrun, underrun;
    logic [31:0] txData, rxData;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: TX buffer, received-word queue and flags
    logic [31:0] m_txbuf;
    bit          m_txrdy, m_ovr, m_unr;
    logic [31:0] m_rxq[$];
    logic [31:0] exp_miso;

    spi_target dut (
        .clk (clk), .rst (rst), .SCLK (SCLK), .MOSI (MOSI), .SS (SS), .MISO (MISO),
        .wide (wide), .txData (txData), .txLoad (txLoad), .txRdy (txRdy),
        .rxData (rxData), .rxRdy (rxRdy), .rxDone (rxDone),
        .overrun (overrun), .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_txrdy = 1'b1;
        m_ovr   = 1'b0;
        m_unr   = 1'b0;
        m_rxq.delete();
    endtask

    // A frame begins: the word it will send is the buffered one, else all ones
    task automatic m_start(input bit wd);
        logic [31:0] v;
        if (!m_txrdy) begin
            v       = m_txbuf;
            m_txrdy = 1'b1;
        end else begin
            v     = 32'hFFFF_FFFF;
            m_unr = 1'b1;
        end
        exp_miso = wd ? v : (v & 32'h0000_00FF);
    endtask

    task automatic m_done(input logic [31:0] w);
`ifdef SPI_TARGET_RXFIFO_EN
        if (m_rxq.size() == 4) m_ovr = 1'b1;
        else m_rxq.push_back(w);
`else
        if (m_rxq.size() != 0) begin
            m_ovr = 1'b1;
            m_rxq.delete();
        end
        m_rxq.push_back(w);
`endif
    endtask

    task automatic tx_load(input logic [31:0] d);
        txData = d;
        txLoad = 1'b1;
        cyc(1);
        txLoad = 1'b0;
        if (m_txrdy) begin
            m_txbuf = d;
            m_txrdy = 1'b0;
        end
    endtask

    task automatic rx_done();
        rxDone = 1'b1;
        cyc(1);
        rxDone = 1'b0;
        if (m_rxq.size() != 0) void'(m_rxq.pop_front());
`ifdef SPI_TARGET_RXFIFO_EN
        if (m_rxq.size() == 0) m_ovr = 1'b0;
`else
        m_rxq.delete();
        m_ovr = 1'b0;
`endif
    endtask

    task automatic reset_dut();
        rst = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; txLoad = 1'b0; rxDone = 1'b0;
        cyc(3);
        rst = 1'b0;
        m_reset();
        cyc(2);
        check("rst_miso", 32'(MISO), 32'd1);
        check("rst_txRdy", 32'(txRdy), 32'd1);
        check("rst_rxRdy", 32'(rxRdy), 32'd0);
        check("rst_rxData", rxData, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
    endtask

    // Clock nbits out of w in wire order; returns MISO reassembled the same way
    task automatic shift(input int nbits, input logic [31:0] w, output logic [31:0] got);
        got = 32'h0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = (i / 8) * 8 + 7 - (i % 8);
            MOSI = w[idx];
            cyc(8);
            got[idx] = MISO;
            SCLK = 1'b1;
            cyc(8);
            SCLK = 1'b0;
        end
    endtask

    task automatic check_status();
        check("rxRdy", 32'(rxRdy), 32'(m_rxq.size() != 0));
        if (m_rxq.size() != 0) check("rxData", rxData, m_rxq[0]);
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("underrun", 32'(underrun), 32'(m_unr));
        check("txRdy", 32'(txRdy), 32'(m_txrdy));
        check("miso_idle", 32'(MISO), 32'd1);
    endtask

    // One SS-low session of up to two frames; the last may be cut short
    task automatic session(input bit wd, input int nframes, input int abort_bits,
                           input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] got, w;
        int nb;
        nb   = wd ? 32 : 8;
        wide = wd;
        SS   = 1'b0;
        m_start(wd);
        for (int f = 0; f < nframes; f++) begin
            w = (f == 0) ? w0 : w1;
            if ((f == nframes - 1) && (abort_bits > 0)) begin
                shift(abort_bits, w, got);
            end else begin
                shift(nb, w, got);
                check("miso_word", got, exp_miso);
                m_done(wd ? w : {24'h0, w[7:0]});
                m_start(wd);
            end
        end
        cyc(8);
        SS = 1'b1;
        cyc(8);
        check_status();
    endtask

    initial begin
        logic [31:0] scratch;
        rst = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; wide = 1'b0;
        txLoad = 1'b0; txData = 32'h0; rxDone = 1'b0;
        reset_dut();

        // 8-bit echo: A5 out, 3C in
        tx_load(32'h0000_00A5);
        check("txRdy_full", 32'(txRdy), 32'd0);
        session(1'b0, 1, 0, 32'h0000_003C, 32'h0);

        // 32-bit byte order
        rx_done();
        tx_load(32'h1122_3344);
        session(1'b1, 1, 0, 32'hDEAD_BEEF, 32'h0);

        // Underrun after a fresh reset: filler out, data still received
        reset_dut();
        session(1'b0, 1, 0, 32'h0000_005A, 32'h0);

        // Back-to-back frames without acknowledge
        rx_done();
        session(1'b0, 2, 0, 32'h0000_0001, 32'h0000_0002);
        rx_done();
        check_status();

        // Abort after 5 bits, then a clean frame
        session(1'b0, 1, 5, 32'h0000_00C3, 32'h0);
        rx_done();
        session(1'b0, 1, 0, 32'h0000_007E, 32'h0);

        // Reset during bit 3
        tx_load(32'h0000_0099);
        wide = 1'b0;
        SS   = 1'b0;
        shift(3, 32'h0000_0055, scratch);
        MOSI = 1'b1;
        cyc(4);
        SCLK = 1'b1;
        cyc(2);
        reset_dut();
        tx_load(32'h0000_0042);
        session(1'b0, 1, 0, 32'h0000_00A3, 32'h0);

        // Randomized sessions
        for (int k = 0; k < 16; k++) begin
            bit wd;
            int nf, ab;
            if ($urandom % 2 == 0) rx_done();
            if ($urandom % 3 != 0) tx_load($urandom);
            if ($urandom % 4 == 0) tx_load($urandom);
            wd = 1'($urandom % 2);
            nf = 1 + int'($urandom % 2);
            ab = ($urandom % 4 == 0) ? int'($urandom_range(1, wd ? 31 : 7)) : 0;
            session(wd, nf, ab, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
